// File: rtl/slot_pkg.sv
// slot_pkg: shared states, widths and symbol pay values for the slot machine controller
package slot_pkg;
  localparam int SYM_W = 3;
  localparam int CREDIT_W = 7;
  localparam int WIN_W = 5;
  typedef enum logic [2:0] {IDLE, READY, SPIN, SETTLE, EVAL, PAYOUT, LOCK} state_t;
  typedef logic [SYM_W-1:0] sym_t;
  function automatic logic [WIN_W-1:0] pay_value(input sym_t s);
    return (s >= 3'd1 && s <= 3'd4) ? WIN_W'(s) : '0;
  endfunction
  function automatic logic [WIN_W-1:0] line_pay(input sym_t a, input sym_t b, input sym_t c);
    return (a == b && b == c) ? pay_value(a) : '0;
  endfunction
endpackage

// File: rtl/slot_line_score.sv
// slot_line_score: combinational win over the five pay lines of a sampled 3x3 window
module slot_line_score
  import slot_pkg::*;
(
  input  logic [9*SYM_W-1:0] syms,
  output logic [WIN_W-1:0]   win
);
  logic [3*SYM_W-1:0] r0, r1, r2;
  assign {r2, r1, r0} = syms;
  // three rows plus the two diagonals through the centre symbol
  always_comb begin
    win = line_pay(r0[8:6], r1[8:6], r2[8:6])
        + line_pay(r0[5:3], r1[5:3], r2[5:3])
        + line_pay(r0[2:0], r1[2:0], r2[2:0])
        + line_pay(r0[8:6], r1[5:3], r2[2:0])
        + line_pay(r0[2:0], r1[5:3], r2[8:6]);
  end
endmodule

// File: rtl/slot_game_ctrl.sv
// slot_game_ctrl: credit, reel sequencing, scoring and cash-out control for the slot machine
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int BET = 1,
  parameter int CREDIT_MAX = 99,
  parameter int AUTO_STOP_CYCLES = 50_000_000,
  parameter int SETTLE_CYCLES = 4
)(
  input  logic                clk,
  input  logic                clrb,
  input  logic                coin_pulse,
  input  logic                start_pulse,
  input  logic                stop_pulse,
  input  logic                cash_out_pulse,
  input  logic [3*SYM_W-1:0]  reel0_sym,
  input  logic [3*SYM_W-1:0]  reel1_sym,
  input  logic [3*SYM_W-1:0]  reel2_sym,
  output logic [2:0]          reel_run,
  output logic [CREDIT_W-1:0] credit,
  output logic [WIN_W-1:0]    win_amount,
  output logic                win_valid,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] cash_amount,
  output logic                cash_done,
  output logic                locked,
  output logic                busy
);
  localparam int TW = AUTO_STOP_CYCLES > 1 ? $clog2(AUTO_STOP_CYCLES) : 1;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW8 = CREDIT_W + 1;
  localparam logic [TW-1:0] T_LAST = TW'(AUTO_STOP_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] BET_C = CREDIT_W'(BET);
  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(CREDIT_MAX);
  localparam logic [CW8-1:0] MAX8 = CW8'(CREDIT_MAX);
  state_t             state;
  logic [1:0]         idx;
  logic [TW-1:0]      timer;
  logic [SW-1:0]      scnt;
  logic [9*SYM_W-1:0] syms;
  logic [WIN_W-1:0]   score;
  logic               cash_now, bet_now, coin_ok;
  logic [CW8-1:0]     sum;
  logic [CREDIT_W-1:0] credit_sat;

  slot_line_score u_score (
    .syms (syms),
    .win  (score)
  );

  // one combined credit update per cycle: coin, bet and payout folded into a saturated sum
  always_comb begin
    cash_now = cash_out_pulse && (state == IDLE || state == READY || state == LOCK);
    bet_now = start_pulse && state == READY && !cash_now;
    coin_ok = coin_pulse && state != LOCK && (credit != MAX_C || bet_now);
    sum = CW8'(credit) + CW8'(coin_ok) + (state == PAYOUT ? CW8'(win_amount) : '0) - (bet_now ? CW8'(BET) : '0);
    credit_sat = sum > MAX8 ? MAX_C : sum[CREDIT_W-1:0];
  end

  // game sequencer with registered outputs; cash-out takes priority in the states that accept it
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state <= IDLE;
      reel_run <= '0;
      credit <= '0;
      win_amount <= '0;
      win_valid <= 1'b0;
      coin_reject <= 1'b0;
      cash_amount <= '0;
      cash_done <= 1'b0;
      locked <= 1'b0;
      busy <= 1'b0;
      idx <= '0;
      timer <= '0;
      scnt <= '0;
      syms <= '0;
    end else begin
      win_valid <= 1'b0;
      cash_done <= 1'b0;
      coin_reject <= coin_pulse && !coin_ok;
      credit <= credit_sat;
      if (cash_now) begin
        cash_amount <= credit_sat;
        cash_done <= 1'b1;
        credit <= '0;
        locked <= 1'b0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (credit_sat >= BET_C) state <= READY;
          READY: begin
            if (bet_now) begin
              reel_run <= 3'b111;
              idx <= '0;
              timer <= '0;
              busy <= 1'b1;
              state <= SPIN;
            end
          end
          SPIN: begin
            if (stop_pulse || timer == T_LAST) begin
              reel_run[idx] <= 1'b0;
              idx <= idx + 2'd1;
              timer <= '0;
              if (idx == 2'd2) begin
                scnt <= '0;
                state <= SETTLE;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          SETTLE: begin
            if (scnt == S_LAST) begin
              syms <= {reel2_sym, reel1_sym, reel0_sym};
              state <= EVAL;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          EVAL: begin
            win_amount <= score;
            win_valid <= 1'b1;
            state <= PAYOUT;
          end
          PAYOUT: begin
            busy <= 1'b0;
            locked <= credit_sat == MAX_C;
            state <= credit_sat == MAX_C ? LOCK : credit_sat >= BET_C ? READY : IDLE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_slot_game_ctrl.sv
// tb_slot_game_ctrl: table-driven scorer checks plus scoreboarded full games on the controller
module tb_slot_game_ctrl;
  import slot_pkg::*;
  logic clk = 1'b0;
  logic clrb = 1'b0;
  logic coin_pulse = 1'b0, start_pulse = 1'b0, stop_pulse = 1'b0, cash_out_pulse = 1'b0;
  logic [8:0] reel0_sym = '0, reel1_sym = '0, reel2_sym = '0;
  logic [2:0] reel_run;
  logic [6:0] credit, cash_amount;
  logic [4:0] win_amount;
  logic win_valid, coin_reject, cash_done, locked, busy;
  logic [26:0] sc_syms = '0;
  logic [4:0] sc_win;
  int total = 0, bad = 0, model = 0;
  typedef struct { logic [8:0] r0, r1, r2; logic [4:0] win; } vec_t;
  typedef struct { logic [4:0] win; logic [6:0] credit; } exp_t;
  vec_t tbl [10];
  exp_t sb [$];

  always #5 clk = ~clk;

  slot_game_ctrl #(.AUTO_STOP_CYCLES(8)) dut (
    .clk(clk), .clrb(clrb), .coin_pulse(coin_pulse), .start_pulse(start_pulse),
    .stop_pulse(stop_pulse), .cash_out_pulse(cash_out_pulse),
    .reel0_sym(reel0_sym), .reel1_sym(reel1_sym), .reel2_sym(reel2_sym),
    .reel_run(reel_run), .credit(credit), .win_amount(win_amount), .win_valid(win_valid),
    .coin_reject(coin_reject), .cash_amount(cash_amount), .cash_done(cash_done),
    .locked(locked), .busy(busy)
  );

  slot_line_score u_sc (.syms(sc_syms), .win(sc_win));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic coins(input int n);
    coin_pulse = 1'b1;
    tick(n);
    coin_pulse = 1'b0;
    model = model + n > 99 ? 99 : model + n;
  endtask

  task automatic start_game(input int vi, input bit with_coin);
    exp_t e;
    reel0_sym = tbl[vi].r0;
    reel1_sym = tbl[vi].r1;
    reel2_sym = tbl[vi].r2;
    coin_pulse = with_coin;
    start_pulse = 1'b1;
    tick();
    coin_pulse = 1'b0;
    start_pulse = 1'b0;
    model = model - 1 + int'(with_coin);
    e.win = tbl[vi].win;
    e.credit = 7'(model + int'(tbl[vi].win) > 99 ? 99 : model + int'(tbl[vi].win));
    sb.push_back(e);
    chk("credit after bet", credit, model);
  endtask

  task automatic stop_reels();
    repeat (3) begin
      tick(2);
      stop_pulse = 1'b1;
      tick();
      stop_pulse = 1'b0;
    end
  endtask

  task automatic finish_game();
    exp_t e;
    int n = 0;
    while (!win_valid && n < 100) begin
      tick();
      n++;
    end
    chk("win_valid seen", win_valid, 1);
    e = sb.pop_front();
    chk("win_amount", win_amount, e.win);
    tick();
    chk("win_valid one cycle", win_valid, 0);
    chk("credit after payout", credit, e.credit);
    model = e.credit;
  endtask

  initial begin
    tbl[0] = '{9'o333, 9'o333, 9'o333, 5'd15};
    tbl[1] = '{9'o000, 9'o000, 9'o000, 5'd0};
    tbl[2] = '{9'o444, 9'o444, 9'o444, 5'd20};
    tbl[3] = '{9'o777, 9'o777, 9'o777, 5'd0};
    tbl[4] = '{9'o102, 9'o215, 9'o601, 5'd1};
    tbl[5] = '{9'o142, 9'o243, 9'o341, 5'd4};
    tbl[6] = '{9'o251, 9'o251, 9'o251, 5'd3};
    tbl[7] = '{9'o404, 9'o142, 9'o464, 5'd8};
    tbl[8] = '{9'o555, 9'o555, 9'o555, 5'd0};
    tbl[9] = '{9'o111, 9'o111, 9'o111, 5'd5};
    for (int i = 0; i < 10; i++) begin
      sc_syms = {tbl[i].r2, tbl[i].r1, tbl[i].r0};
      #1;
      chk($sformatf("score vec%0d", i), sc_win, tbl[i].win);
    end
    tick(2);
    chk("reset reel_run", reel_run, 0);
    chk("reset credit", credit, 0);
    chk("reset busy", busy, 0);
    chk("reset locked", locked, 0);
    chk("reset win_amount", win_amount, 0);
    chk("reset cash_done", cash_done, 0);
    clrb = 1'b1;
    tick();
    coins(1);
    chk("credit coin1", credit, 1);
    coins(1);
    chk("credit coin2", credit, 2);
    start_game(0, 1'b0);
    chk("reel_run start", reel_run, 3'b111);
    chk("busy spin", busy, 1);
    tick(4);
    stop_pulse = 1'b1;
    tick();
    stop_pulse = 1'b0;
    chk("reel_run stop0", reel_run, 3'b110);
    tick(4);
    stop_pulse = 1'b1;
    tick();
    stop_pulse = 1'b0;
    chk("reel_run stop1", reel_run, 3'b100);
    tick(4);
    stop_pulse = 1'b1;
    tick();
    chk("reel_run stop2", reel_run, 3'b000);
    tick();
    stop_pulse = 1'b0;
    finish_game();
    chk("busy after game", busy, 0);
    start_game(1, 1'b0);
    for (int j = 2; j <= 25; j++) begin
      tick();
      if (j == 8 || j == 9 || j == 16 || j == 17 || j == 24 || j == 25)
        chk($sformatf("auto stop reel_run @%0d", j), reel_run,
            j < 9 ? 3'b111 : j < 17 ? 3'b110 : j < 25 ? 3'b100 : 3'b000);
    end
    finish_game();
    coins(83);
    chk("credit 98", credit, 98);
    start_game(4, 1'b1);
    stop_reels();
    finish_game();
    chk("locked at max", locked, 1);
    coin_pulse = 1'b1;
    tick();
    coin_pulse = 1'b0;
    chk("coin_reject in lock", coin_reject, 1);
    chk("credit held in lock", credit, 99);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("start ignored busy", busy, 0);
    chk("start ignored reels", reel_run, 0);
    chk("still locked", locked, 1);
    cash_out_pulse = 1'b1;
    tick();
    cash_out_pulse = 1'b0;
    chk("cash_done", cash_done, 1);
    chk("cash_amount 99", cash_amount, 99);
    chk("credit after cash", credit, 0);
    chk("unlocked", locked, 0);
    tick();
    chk("cash_done one cycle", cash_done, 0);
    model = 0;
    coins(98);
    start_game(5, 1'b0);
    stop_reels();
    finish_game();
    chk("locked after saturate", locked, 1);
    coin_pulse = 1'b1;
    cash_out_pulse = 1'b1;
    tick();
    chk("lock cash with coin", cash_amount, 99);
    chk("lock coin rejected", coin_reject, 1);
    chk("credit cleared", credit, 0);
    tick();
    coin_pulse = 1'b0;
    cash_out_pulse = 1'b0;
    chk("idle cash with coin", cash_amount, 1);
    chk("credit zero again", credit, 0);
    model = 0;
    coins(2);
    start_pulse = 1'b1;
    cash_out_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    cash_out_pulse = 1'b0;
    chk("cash beats start done", cash_done, 1);
    chk("cash beats start amount", cash_amount, 2);
    chk("cash beats start busy", busy, 0);
    chk("cash beats start reels", reel_run, 0);
    model = 0;
    coins(6);
    start_game(2, 1'b0);
    tick(3);
    #2;
    clrb = 1'b0;
    #1;
    chk("clrb reel_run", reel_run, 0);
    chk("clrb credit", credit, 0);
    chk("clrb busy", busy, 0);
    tick();
    clrb = 1'b1;
    sb.delete();
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("idle start ignored", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
